// File: rtl/comparator_pkg.sv
// Shared widths for the lockstep write comparator.
package comparator_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ERR_CNT_W      = 8;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    // Saturating increment so the error count never wraps back to a small value.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/comparator.sv
// Votes the register-file write port of two lockstep copies; blocks and counts disagreeing writes.
// Latency 1 cycle on every output; no backpressure, a new compare is accepted every cycle.
module comparator
    import comparator_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_a_i,
    input  logic                  we_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  we_o,
    output logic                  signal,
    output logic [ERR_CNT_W-1:0]  err_cnt_o
);

    logic                  mismatch;
    logic [ADDR_WIDTH-1:0] addr_d,   addr_q;
    logic [DATA_WIDTH-1:0] data_d,   data_q;
    logic                  we_d,     we_q;
    logic                  sig_d,    sig_q;
    logic [ERR_CNT_W-1:0]  errcnt_d, errcnt_q;

    // Address/data only matter when both copies actually write.
    always_comb begin
        mismatch = 1'b0;
        if (we_a_i != we_b_i) begin
            mismatch = 1'b1;
        end else if (we_a_i && ((addr_a_i != addr_b_i) || (data_a_i != data_b_i))) begin
            mismatch = 1'b1;
        end
    end

    always_comb begin
        addr_d   = addr_a_i;
        data_d   = data_a_i;
        we_d     = we_a_i && we_b_i && !mismatch;
        sig_d    = mismatch;
        errcnt_d = mismatch ? sat_inc(errcnt_q) : errcnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            sig_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            sig_q    <= sig_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign we_o      = we_q;
    assign signal    = sig_q;
    assign err_cnt_o = errcnt_q;

endmodule

// File: tb/tb_comparator.sv
// Randomized and directed bench for comparator against a behavioural model.
module tb_comparator;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          we_a_i = 1'b0, we_b_i = 1'b0;
    logic [AW-1:0] addr_a_i = '0, addr_b_i = '0;
    logic [DW-1:0] data_a_i = '0, data_b_i = '0;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_o;
    logic          we_o;
    logic          signal;
    logic [7:0]    err_cnt_o;

    comparator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_a_i   (we_a_i),
        .we_b_i   (we_b_i),
        .addr_a_i (addr_a_i),
        .addr_b_i (addr_b_i),
        .data_a_i (data_a_i),
        .data_b_i (data_b_i),
        .addr_o   (addr_o),
        .data_o   (data_o),
        .we_o     (we_o),
        .signal   (signal),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: what the outputs must show after the next clock edge.
    int          m_addr, m_data;
    bit          m_we, m_sig;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare every output.
    task automatic step(input bit rst, input bit wa, input bit wb,
                        input int aa, input int ab, input int da, input int db);
        bool_t_dummy: begin end
        rst_i = rst; we_a_i = wa; we_b_i = wb;
        addr_a_i = aa[AW-1:0]; addr_b_i = ab[AW-1:0];
        data_a_i = da[DW-1:0]; data_b_i = db[DW-1:0];
        if (rst) begin
            m_addr = 0; m_data = 0; m_we = 0; m_sig = 0; m_cnt = 0;
        end else begin
            bit agree;
            agree  = (wa == wb) && (!(wa && wb) ||
                     ((aa % (1 << AW)) == (ab % (1 << AW)) && da == db));
            m_addr = aa % (1 << AW);
            m_data = da;
            m_we   = wa && wb && agree;
            m_sig  = !agree;
            if (!agree && m_cnt < 255) m_cnt = m_cnt + 1;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        chk("addr_o",    64'(addr_o),    64'(m_addr[AW-1:0]));
        chk("data_o",    64'(data_o),    64'(m_data[DW-1:0]));
        chk("we_o",      64'(we_o),      64'(m_we));
        chk("signal",    64'(signal),    64'(m_sig));
        chk("err_cnt_o", 64'(err_cnt_o), 64'(m_cnt));
    endtask

    initial begin
        // Reset, with a mismatch present that must not be counted.
        step(1, 1, 0, 3, 4, 5, 6);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_we",   64'(we_o),      64'd0);
        chk("rst_sig",  64'(signal),    64'd0);
        chk("rst_cnt",  64'(err_cnt_o), 64'd0);
        chk("rst_data", 64'(data_o),    64'd0);

        step(0, 1, 1, 10, 10, 100, 100);
        chk("match_we",   64'(we_o),      64'd1);
        chk("match_sig",  64'(signal),    64'd0);
        chk("match_addr", 64'(addr_o),    64'd10);
        chk("match_data", 64'(data_o),    64'd100);
        chk("match_cnt",  64'(err_cnt_o), 64'd0);

        step(0, 1, 0, 10, 10, 100, 100);
        chk("we_mm_sig", 64'(signal),    64'd1);
        chk("we_mm_we",  64'(we_o),      64'd0);
        chk("we_mm_cnt", 64'(err_cnt_o), 64'd1);

        step(0, 1, 1, 10, 11, 100, 100);
        chk("addr_mm_sig", 64'(signal),    64'd1);
        chk("addr_mm_we",  64'(we_o),      64'd0);
        chk("addr_mm_cnt", 64'(err_cnt_o), 64'd2);

        step(0, 1, 1, 10, 10, 120, 100);
        chk("data_mm_sig",  64'(signal),    64'd1);
        chk("data_mm_we",   64'(we_o),      64'd0);
        chk("data_mm_data", 64'(data_o),    64'd120);
        chk("data_mm_cnt",  64'(err_cnt_o), 64'd3);

        step(0, 1, 1, 10, 10, 120, 120);
        chk("recover_sig",  64'(signal), 64'd0);
        chk("recover_we",   64'(we_o),   64'd1);
        chk("recover_data", 64'(data_o), 64'd120);

        step(0, 0, 0, 3, 7, 1, 2);
        chk("idle_sig", 64'(signal),    64'd0);
        chk("idle_we",  64'(we_o),      64'd0);
        chk("idle_cnt", 64'(err_cnt_o), 64'd3);

        // Random traffic, biased towards agreement, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            int  aa, ab, da, db;
            bit  wa, wb, rst;
            rst = ($urandom_range(0, 99) == 0);
            wa  = $urandom_range(0, 1);
            wb  = ($urandom_range(0, 3) == 0) ? !wa : wa;
            aa  = $urandom_range(0, 31);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : aa;
            da  = int'($urandom);
            db  = ($urandom_range(0, 3) == 0) ? da ^ (1 << $urandom_range(0, 31)) : da;
            step(rst, wa, wb, aa, ab, da, db);
        end

        // Saturation: long run of mismatches from a clean count.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 1, i, i, i, i + 1);
            if (i == 0) chk("sat_first_cnt", 64'(err_cnt_o), 64'd1);
            if (i > 0) chk("sat_sig_held", 64'(signal), 64'd1);
        end
        chk("sat_cnt", 64'(err_cnt_o), 64'd255);

        // Reset mid-stream while a mismatch is still being driven.
        step(1, 1, 0, 9, 9, 77, 77);
        chk("midrst_cnt",  64'(err_cnt_o), 64'd0);
        chk("midrst_sig",  64'(signal),    64'd0);
        chk("midrst_we",   64'(we_o),      64'd0);
        chk("midrst_addr", 64'(addr_o),    64'd0);
        chk("midrst_data", 64'(data_o),    64'd0);

        step(0, 1, 0, 2, 2, 5, 5);
        chk("post_rst_cnt", 64'(err_cnt_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register-file address width.
REQ-002 Parameter DATA_WIDTH, default 32, write-data width.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 we_a_i  input  1  write enable from copy A.
REQ-006 we_b_i  input  1  write enable from copy B.
REQ-007 addr_a_i  input  ADDR_WIDTH  write address from copy A.
REQ-008 addr_b_i  input  ADDR_WIDTH  write address from copy B.
REQ-009 data_a_i  input  DATA_WIDTH  write data from copy A.
REQ-010 data_b_i  input  DATA_WIDTH  write data from copy B.
REQ-011 addr_o  output  ADDR_WIDTH  voted write address.
REQ-012 data_o  output  DATA_WIDTH  voted write data.
REQ-013 we_o  output  1  qualified write enable, high only for agreeing writes.
REQ-014 signal  output  1  mismatch flag, high for one cycle per disagreeing input cycle.
REQ-015 err_cnt_o  output  8  saturating count of mismatch cycles since reset.

Function
REQ-016 A cycle SHALL be a mismatch when we_a_i != we_b_i, or when both enables are 1 and (addr_a_i != addr_b_i or data_a_i != data_b_i).
REQ-017 When both enables are 0, the cycle SHALL be a match regardless of address and data values.
REQ-018 All outputs SHALL be registered, with a latency of exactly one clock cycle from inputs to outputs.
REQ-019 addr_o and data_o SHALL capture addr_a_i and data_a_i every non-reset cycle, for both match and mismatch.
REQ-020 we_o SHALL be 1 only when both enables are 1 and the cycle is a match; it SHALL be 0 on any mismatch, which blocks the write.
REQ-021 signal SHALL be 1 in the cycle after a mismatch and 0 otherwise; it is not sticky.
REQ-022 Consecutive mismatch cycles SHALL keep signal high continuously.
REQ-023 err_cnt_o SHALL increment by 1 for each mismatch cycle and saturate at 255 without wrapping.
REQ-024 Address and data comparison SHALL be full-width equality; X-free inputs are required.

Reset
REQ-025 While rst_i is high at a clock edge, the block SHALL set addr_o=0, data_o=0, we_o=0, signal=0 and err_cnt_o=0.
REQ-026 Reset SHALL take priority over any compare in the same cycle.
REQ-027 A mismatch present during reset SHALL be neither flagged nor counted.
REQ-028 The first compare SHALL occur in the first cycle with rst_i low.

Structure
REQ-029 A shared package SHALL hold the default ADDR_WIDTH and DATA_WIDTH constants and the counter width constant ERR_CNT_W=8.
REQ-030 The block SHALL be a single module with no sub-modules.
REQ-031 The mismatch decode SHALL be combinational, feeding one registered output stage.

Verification
REQ-032 we=1/1, addr=10/10, data=100/100 -> next cycle: signal=0, we_o=1, addr_o=10, data_o=100, err_cnt_o unchanged.
REQ-033 we=1/0, addr=10/10, data=100/100 -> signal=1, we_o=0, err_cnt_o+1.
REQ-034 We=1/1 with either of the following -> signal=1, we_o=0, data_o=120 in the data case:
- addr=10/11, data=100/100;
- addr=10/10, data=120/100.
REQ-035 we=1/1, addr=10/10, data=120/120 following a mismatch -> signal=0, we_o=1, data_o=120.
REQ-036 We=0/0 with addr=3/7 and data=1/2 -> signal=0, we_o=0, no count.
REQ-037 300 consecutive mismatch cycles, then rst_i asserted mid-stream:
- err_cnt_o holds at 255;
- all outputs are 0 on the cycle after the reset edge.
